// File: rtl/fa_ha_reg.sv
// fa_ha_reg: registered ripple-carry adder.
//   Each bit is a full-adder cell built from two half adders and an OR gate.
//   {cout, sum} captures a + b + cin on a rising clk edge when in_valid is
//   high and holds otherwise. out_valid pulses for the cycle that follows
//   each capture.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears sum, cout, out_valid)
//   in_valid  sample a, b and cin on this edge
//   a, b      WIDTH-bit unsigned addends
//   cin       carry into bit 0
//   sum       registered WIDTH-bit sum
//   cout      registered carry out of bit WIDTH-1
//   out_valid high for one cycle per newly captured result

// Half adder: s = a ^ b, c = a & b.
module fa_ha_reg_ha (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module fa_ha_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  // Ripple chain: c[0] is cin, c[WIDTH] is the carry out of the top bit.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g1;
  logic [WIDTH-1:0] g2;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    // First HA forms propagate/generate from the operand bits.
    fa_ha_reg_ha u_ha1 (
      .a_i (a[i]),
      .b_i (b[i]),
      .s_o (p[i]),
      .c_o (g1[i])
    );
    // Second HA folds in the incoming carry.
    fa_ha_reg_ha u_ha2 (
      .a_i (p[i]),
      .b_i (c[i]),
      .s_o (s[i]),
      .c_o (g2[i])
    );
    assign c[i+1] = g1[i] | g2[i];
  end

  // ---- Output register stage ----
  logic [WIDTH-1:0] sum_q,  sum_d;
  logic             cout_q, cout_d;
  logic             vld_q,  vld_d;

  // Inputs are only looked at when in_valid is high, so X/Z on a, b, cin
  // during idle cycles never reaches the registers.
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    vld_d  = in_valid;
    if (in_valid) begin
      sum_d  = s;
      cout_d = c[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_fa_ha_reg.sv
module tb_fa_ha_reg;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a_s;
  logic [7:0] b_s;
  logic       cin;

  logic [0:0] sum1;
  logic       cout1;
  logic       ov1;
  logic [7:0] sum8;
  logic       cout8;
  logic       ov8;

  int n_tests = 0;
  int n_fail  = 0;

  fa_ha_reg #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a_s[0:0]),
    .b         (b_s[0:0]),
    .cin       (cin),
    .sum       (sum1),
    .cout      (cout1),
    .out_valid (ov1)
  );

  fa_ha_reg #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a_s),
    .b         (b_s),
    .cin       (cin),
    .sum       (sum8),
    .cout      (cout8),
    .out_valid (ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       b;
    logic       ci;
    logic [1:0] exp;   // {cout, sum}
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [8:0] exp;   // {cout, sum}
  } vec8_t;

  vec1_t tt1[8];
  vec8_t tt8[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic c);
    in_valid = v;
    a_s      = av;
    b_s      = bv;
    cin      = c;
  endtask

  logic [8:0] ref8;
  logic [8:0] hold8;
  logic [7:0] ra, rb;
  logic       rc;
  logic       gate_v[5];
  logic       gate_allv;

  initial begin
    // {a,b,cin} = 000..111 -> {cout,sum}
    tt1[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
    tt1[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
    tt1[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
    tt1[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
    tt1[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
    tt1[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
    tt1[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
    tt1[7] = '{1'b1, 1'b1, 1'b1, 2'b11};

    tt8[0] = '{8'hFF, 8'h00, 1'b1, 9'h100};
    tt8[1] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    tt8[2] = '{8'h00, 8'h00, 1'b0, 9'h000};
    tt8[3] = '{8'h80, 8'h80, 1'b0, 9'h100};
    tt8[4] = '{8'h55, 8'hAA, 1'b0, 9'h0FF};
    tt8[5] = '{8'h0F, 8'h01, 1'b1, 9'h011};

    gate_v[0] = 1'b1; gate_v[1] = 1'b0; gate_v[2] = 1'b1;
    gate_v[3] = 1'b1; gate_v[4] = 1'b0;

    // ---- reset state ----
    rst_n = 1'b1;
    drive(1'b1, 8'hFF, 8'hFF, 1'b1);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_sum8", sum8, 0);
    chk("rst_cout8", cout8, 0);
    chk("rst_ov8", ov8, 0);
    chk("rst_sum1", sum1, 0);
    chk("rst_ov1", ov1, 0);
    tick();
    chk("rst_hold_ov8", ov8, 0);
    chk("rst_hold_sum8", sum8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    tick();

    // ---- 1-bit truth table, back to back ----
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, {7'b0, tt1[i].a}, {7'b0, tt1[i].b}, tt1[i].ci);
      tick();
      chk($sformatf("tt1_%0d", i), {cout1, sum1}, tt1[i].exp);
      chk($sformatf("tt1_ov_%0d", i), ov1, 1);
    end

    // ---- 8-bit directed vectors incl. carry-chain boundaries ----
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, tt8[i].a, tt8[i].b, tt8[i].ci);
      tick();
      chk($sformatf("tt8_%0d", i), {cout8, sum8}, tt8[i].exp);
      chk($sformatf("tt8_ov_%0d", i), ov8, 1);
    end

    // ---- hold: capture 1+1+0, then idle with different (and X) inputs ----
    drive(1'b1, 8'h01, 8'h01, 1'b0);
    tick();
    chk("hold_cap1", {cout1, sum1}, 2'b10);
    chk("hold_cap8", {cout8, sum8}, 9'h002);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 8'h00, 8'h00, 1'b1);
      if (k == 2) begin
        a_s = 'x;
        b_s = 'x;
        cin = 1'bx;
      end
      tick();
      chk($sformatf("hold1_%0d", k), {cout1, sum1}, 2'b10);
      chk($sformatf("hold8_%0d", k), {cout8, sum8}, 9'h002);
      chk($sformatf("hold_ov_%0d", k), ov1, 0);
    end

    // ---- async reset between edges ----
    drive(1'b1, 8'h01, 8'h01, 1'b1);
    tick();
    chk("pre_rst1", {cout1, sum1}, 2'b11);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #0.5;
    chk("arst_sum1", sum1, 0);
    chk("arst_cout1", cout1, 0);
    chk("arst_ov1", ov1, 0);
    chk("arst_out8", {cout8, sum8}, 0);
    #1 rst_n = 1'b1;
    tick();
    // captured result must not reappear after reset
    chk("post_rst_idle", {cout1, sum1}, 0);
    chk("post_rst_ov", ov1, 0);
    drive(1'b1, 8'h00, 8'h01, 1'b0);
    tick();
    chk("post_rst_cap", {cout1, sum1}, 2'b01);
    chk("post_rst_ov2", ov1, 1);

    // ---- random back-to-back, WIDTH=8 ----
    gate_allv = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      drive(1'b1, ra, rb, rc);
      ref8 = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      tick();
      if ({cout8, sum8} !== ref8) chk($sformatf("rand_%0d", i), {cout8, sum8}, ref8);
      else n_tests++;
      if (ov8 !== 1'b1) gate_allv = 1'b0;
    end
    chk("rand_ov_cont", gate_allv, 1);

    // ---- valid gating 1,0,1,1,0 ----
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    chk("gate_ov_pre", ov8, 0);
    hold8 = {cout8, sum8};
    for (int i = 0; i < 5; i++) begin
      ra = 8'(8'h10 * i + 8'h03);
      rb = 8'(8'hF0 - 8'h11 * i);
      drive(gate_v[i], ra, rb, 1'b1);
      if (gate_v[i]) hold8 = {1'b0, ra} + {1'b0, rb} + 9'd1;
      tick();
      chk($sformatf("gate_ov_%0d", i), ov8, gate_v[i]);
      chk($sformatf("gate_data_%0d", i), {cout8, sum8}, hold8);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
